// File: rtl/seq_pkg.sv
// Shared types and default widths for the program sequencer.
package seq_pkg;

  localparam int PW_DEF = 3;
  localparam int CW_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_RECORD   = 3'd3,
    ST_DONE     = 3'd4
  } seq_state_e;

endpackage

// File: rtl/seq_run_counter.sv
// Per-run cycle counter: synchronous clear, enable, saturates at all-ones.
// Terminal-count compare exists only when SEQ_TIMEOUT_EN is defined.
module seq_run_counter #(
  parameter int CW = 16
`ifdef SEQ_TIMEOUT_EN
  , parameter logic [CW-1:0] TC_VAL = {CW{1'b1}}
`endif
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_en,
`ifdef SEQ_TIMEOUT_EN
  output logic          o_tc,
`endif
  output logic [CW-1:0] o_count
);

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] r_count;

  // Counter holds at all-ones rather than wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= {CW{1'b0}};
    end else if (i_clr) begin
      r_count <= {CW{1'b0}};
    end else if (i_en && (r_count != {CW{1'b1}})) begin
      r_count <= r_count + ONE;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;
`ifdef SEQ_TIMEOUT_EN
  assign o_tc = (r_count == TC_VAL);
`endif

endmodule

// File: rtl/program_sequencer.sv
// Host-side Start/Ack initiator: runs NumProgs programs back to back and
// reports per-run cycle counts. Watchdog compiled in with SEQ_TIMEOUT_EN.
module program_sequencer import seq_pkg::*; #(
  parameter int              PW        = PW_DEF,
  parameter int              CW        = CW_DEF,
  parameter int              START_LEN = 2,
  parameter logic [CW-1:0]   TIMEOUT   = {CW{1'b1}}
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Go,
  input  logic [PW-1:0] NumProgs,
  input  logic          DutAck,
  output logic          DutStart,
  output logic [PW-1:0] ProgSel,
  output logic          Busy,
  output logic          Done,
  output logic          RunValid,
  output logic [PW-1:0] RunIdx,
  output logic [CW-1:0] RunCycles,
  output logic          RunTimeout,
  output logic [PW:0]   FailCount
);

  localparam int              SLW    = $clog2(START_LEN) + 1;
  localparam logic [SLW-1:0]  S_LAST = SLW'(START_LEN - 1);
  localparam logic [SLW-1:0]  S_ONE  = {{(SLW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]   P_ONE  = {{(PW-1){1'b0}}, 1'b1};

  seq_state_e    r_state;
  logic [PW-1:0] r_num;
  logic [SLW-1:0] r_slen;
  logic          r_dut_start, r_busy, r_done, r_run_valid;
  logic [PW-1:0] r_prog_sel, r_run_idx;
  logic [CW-1:0] r_run_cycles;
  logic [CW-1:0] w_count;
  logic          w_cnt_clr, w_cnt_en;

  assign w_cnt_clr = (r_state == ST_START);
  assign w_cnt_en  = (r_state == ST_WAIT_ACK) && !DutAck;

`ifdef SEQ_TIMEOUT_EN
  localparam logic [CW-1:0]  C_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [PW:0]    F_ONE  = {{PW{1'b0}}, 1'b1};
  logic          w_tc;
  logic          r_run_timeout;
  logic [PW:0]   r_fail_cnt;

  seq_run_counter #(.CW(CW), .TC_VAL(TIMEOUT - C_ONE)) u_cnt (
    .i_clk(Clk), .i_rst_n(Reset_n), .i_clr(w_cnt_clr), .i_en(w_cnt_en),
    .o_tc(w_tc), .o_count(w_count)
  );

  // Timeout bookkeeping; DutAck takes priority over the terminal count.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_run_timeout <= 1'b0;
      r_fail_cnt    <= {(PW+1){1'b0}};
    end else if ((r_state == ST_IDLE) && Go) begin
      r_run_timeout <= r_run_timeout;
      r_fail_cnt    <= {(PW+1){1'b0}};
    end else if ((r_state == ST_WAIT_ACK) && DutAck) begin
      r_run_timeout <= 1'b0;
      r_fail_cnt    <= r_fail_cnt;
    end else if ((r_state == ST_WAIT_ACK) && w_tc) begin
      r_run_timeout <= 1'b1;
      r_fail_cnt    <= r_fail_cnt + F_ONE;
    end else begin
      r_run_timeout <= r_run_timeout;
      r_fail_cnt    <= r_fail_cnt;
    end
  end

  assign RunTimeout = r_run_timeout;
  assign FailCount  = r_fail_cnt;
`else
  seq_run_counter #(.CW(CW)) u_cnt (
    .i_clk(Clk), .i_rst_n(Reset_n), .i_clr(w_cnt_clr), .i_en(w_cnt_en),
    .o_count(w_count)
  );

  assign RunTimeout = 1'b0;
  assign FailCount  = {(PW+1){1'b0}};
`endif

  // Batch FSM with registered handshake and report outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= ST_IDLE;
      r_num        <= {PW{1'b0}};
      r_slen       <= {SLW{1'b0}};
      r_dut_start  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_run_valid  <= 1'b0;
      r_prog_sel   <= {PW{1'b0}};
      r_run_idx    <= {PW{1'b0}};
      r_run_cycles <= {CW{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Go) begin
            r_num      <= NumProgs;
            r_prog_sel <= {PW{1'b0}};
            r_busy     <= 1'b1;
            r_slen     <= {SLW{1'b0}};
            if (NumProgs == {PW{1'b0}}) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= ST_START;
              r_dut_start <= 1'b1;
            end
          end
        end
        ST_START: begin
          if (r_slen == S_LAST) begin
            r_state     <= ST_WAIT_ACK;
            r_dut_start <= 1'b0;
          end else begin
            r_slen <= r_slen + S_ONE;
          end
        end
        ST_WAIT_ACK: begin
          if (DutAck) begin
            r_state      <= ST_RECORD;
            r_run_valid  <= 1'b1;
            r_run_idx    <= r_prog_sel;
            r_run_cycles <= w_count;
`ifdef SEQ_TIMEOUT_EN
          end else if (w_tc) begin
            r_state      <= ST_RECORD;
            r_run_valid  <= 1'b1;
            r_run_idx    <= r_prog_sel;
            r_run_cycles <= TIMEOUT;
`endif
          end
        end
        ST_RECORD: begin
          r_run_valid <= 1'b0;
          if (r_prog_sel == (r_num - P_ONE)) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_prog_sel  <= r_prog_sel + P_ONE;
            r_state     <= ST_START;
            r_dut_start <= 1'b1;
            r_slen      <= {SLW{1'b0}};
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_dut_start <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_run_valid <= 1'b0;
        end
      endcase
    end
  end

  assign DutStart  = r_dut_start;
  assign ProgSel   = r_prog_sel;
  assign Busy      = r_busy;
  assign Done      = r_done;
  assign RunValid  = r_run_valid;
  assign RunIdx    = r_run_idx;
  assign RunCycles = r_run_cycles;

endmodule

// File: tb/tb_program_sequencer.sv
// Randomised and directed bench for program_sequencer; reference results
// come from the per-run rules (cycles = ack delay, capped by the watchdog).
module tb_program_sequencer;

  localparam int PW = 3;
  localparam int CW = 16;
  localparam int SL = 2;
  localparam int TO = 8;
`ifdef SEQ_TIMEOUT_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          Go = 1'b0;
  logic [PW-1:0] NumProgs = '0;
  logic          DutAck = 1'b0;
  logic          DutStart, Busy, Done, RunValid, RunTimeout;
  logic [PW-1:0] ProgSel, RunIdx;
  logic [CW-1:0] RunCycles;
  logic [PW:0]   FailCount;

  int n_vec = 0;
  int n_err = 0;
  int dly[8];

  always #5 Clk = ~Clk;

  program_sequencer #(.PW(PW), .CW(CW), .START_LEN(SL), .TIMEOUT(16'd8)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Go(Go), .NumProgs(NumProgs), .DutAck(DutAck),
    .DutStart(DutStart), .ProgSel(ProgSel), .Busy(Busy), .Done(Done),
    .RunValid(RunValid), .RunIdx(RunIdx), .RunCycles(RunCycles),
    .RunTimeout(RunTimeout), .FailCount(FailCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ds"}, DutStart, 0);
    chk({tag, "_psel"}, ProgSel, 0);
    chk({tag, "_busy"}, Busy, 0);
    chk({tag, "_done"}, Done, 0);
    chk({tag, "_rv"}, RunValid, 0);
    chk({tag, "_ridx"}, RunIdx, 0);
    chk({tag, "_rcyc"}, RunCycles, 0);
    chk({tag, "_rto"}, RunTimeout, 0);
    chk({tag, "_fail"}, FailCount, 0);
  endtask

  // One batch of n programs using ack delays dly[0..n-1].
  task automatic run_batch(input int n, input bit stale);
    int t, ds_cnt, fails, lat, exp_cyc;
    bit exp_to;
    NumProgs = PW'(n);
    Go = 1'b1;
    @(negedge Clk);
    Go = 1'b0;
    NumProgs = PW'($urandom);
    chk("busy_after_go", Busy, 1);
    if (n == 0) begin
      chk("done_empty", Done, 1);
      chk("ds_empty", DutStart, 0);
      chk("rv_empty", RunValid, 0);
      @(negedge Clk);
      chk("done_empty_end", Done, 0);
      chk("busy_empty_end", Busy, 0);
      chk("ds_empty_end", DutStart, 0);
      return;
    end
    fails = 0;
    for (int i = 0; i < n; i++) begin
      DutAck = stale;
      ds_cnt = 0;
      while (DutStart === 1'b1 && ds_cnt < 10) begin
        ds_cnt++;
        @(negedge Clk);
      end
      chk("start_len", ds_cnt, SL);
      chk("progsel_run", ProgSel, i);
      exp_to  = WD && (dly[i] >= TO);
      exp_cyc = exp_to ? TO : dly[i];
      lat     = exp_to ? TO : dly[i] + 1;
      t = 0;
      DutAck = (dly[i] == 0);
      while (RunValid !== 1'b1 && t < dly[i] + TO + 4) begin
        @(negedge Clk);
        t++;
        if (t == dly[i]) DutAck = 1'b1;
      end
      chk("rv_latency", t, lat);
      chk("run_idx", RunIdx, i);
      chk("run_cycles", RunCycles, exp_cyc);
      chk("run_timeout", RunTimeout, exp_to);
      chk("progsel_record", ProgSel, i);
      if (exp_to) fails++;
      DutAck = stale;
      @(negedge Clk);
      chk("rv_pulse", RunValid, 0);
      chk("hold_cycles", RunCycles, exp_cyc);
      if (i == n - 1) begin
        chk("done", Done, 1);
        chk("failcount", FailCount, fails);
        @(negedge Clk);
        chk("done_pulse", Done, 0);
        chk("busy_end", Busy, 0);
      end else begin
        chk("next_start", DutStart, 1);
      end
    end
    DutAck = 1'b0;
  endtask

  initial begin
    int t;
    @(negedge Clk);
    chk_reset_vals("reset");
    Reset_n = 1'b1;
    @(negedge Clk);

    dly[0] = 10;
    run_batch(1, 1'b0);
    dly[0] = 0; dly[1] = 5; dly[2] = 1;
    run_batch(3, 1'b0);
    dly[0] = 3; dly[1] = 0;
    run_batch(2, 1'b1);
    run_batch(0, 1'b0);
    if (WD) begin
      dly[0] = 100; dly[1] = TO - 1; dly[2] = TO;
      run_batch(3, 1'b0);
    end
    for (int b = 0; b < 6; b++) begin
      for (int k = 0; k < 8; k++) dly[k] = $urandom_range(0, 12);
      run_batch($urandom_range(1, 4), 1'($urandom_range(0, 1)));
    end

    // Reset mid-run: in START (DutStart high) and in WAIT_ACK.
    for (int k = 0; k < 2; k++) begin
      dly[0] = 4; dly[1] = 2;
      run_batch(2, 1'b0);
      NumProgs = 3'd2;
      Go = 1'b1;
      @(negedge Clk);
      Go = 1'b0;
      if (k == 1) begin
        @(negedge Clk);
        @(negedge Clk);
      end else begin
        chk("ds_before_rst", DutStart, 1);
      end
      #2 Reset_n = 1'b0;
      #1 chk_reset_vals("async_rst");
      @(negedge Clk);
      chk("rst_rv", RunValid, 0);
      chk("rst_done", Done, 0);
      Reset_n = 1'b1;
      @(negedge Clk);
      chk("post_rst_busy", Busy, 0);
    end

    // Go while busy with a new NumProgs must not re-launch or re-latch.
    NumProgs = 3'd1;
    Go = 1'b1;
    @(negedge Clk);
    Go = 1'b0;
    NumProgs = 3'd5;
    @(negedge Clk);
    @(negedge Clk);
    chk("wait_ds", DutStart, 0);
    Go = 1'b1;
    repeat (3) @(negedge Clk);
    Go = 1'b0;
    DutAck = 1'b1;
    t = 0;
    while (RunValid !== 1'b1 && t < 20) begin
      @(negedge Clk);
      t++;
    end
    chk("busygo_lat", t, 1);
    chk("busygo_idx", RunIdx, 0);
    chk("busygo_cyc", RunCycles, 3);
    @(negedge Clk);
    chk("busygo_done", Done, 1);
    chk("busygo_ds", DutStart, 0);
    DutAck = 1'b0;
    @(negedge Clk);
    chk("busygo_idle", Busy, 0);
    @(negedge Clk);
    chk("busygo_no_relaunch", DutStart, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Host-side initiator for the processor's Start/Ack run handshake: launches a batch of programs on the core one after another and measures each one. For every program it drives the program select, pulses Start, waits for Ack (the all-ones halt instruction), and reports the cycle count and a timeout flag. It sits between the bench/host and the processor top level. It is the driving end of the same protocol the core implements.

## Interface
- PW, 3, width of program index / program select
- CW, 16, width of per-run cycle counter
- START_LEN, 2, cycles DutStart is held high per launch (≥1)
- TIMEOUT, 16'hFFFF, watchdog limit in WAIT_ACK cycles (only with SEQ_TIMEOUT_EN)

Ports:
- Clk  in  1  clock, posedge only
- Reset_n  in  1  asynchronous, active-low reset
- Go  in  1  launch request, sampled only in IDLE
- NumProgs  in  PW  number of programs to run, latched on accepted Go
- DutAck  in  1  core done flag (level, held while halted)
- DutStart  out  1  Start to core
- ProgSel  out  PW  index of program being run, stable from START through RECORD
- Busy  out  1  high in every state except IDLE
- Done  out  1  one-cycle pulse when the batch completes
- RunValid  out  1  one-cycle pulse per finished program
- RunIdx  out  PW  program index for RunValid
- RunCycles  out  CW  WAIT_ACK cycles with DutAck low before halt
- RunTimeout  out  1  run ended by watchdog, qualified by RunValid
- FailCount  out  PW+1  timeouts in current batch, cleared on accepted Go

## Operation
- States: IDLE, START, WAIT_ACK, RECORD, DONE.
- IDLE: on Go=1, latch NumProgs, clear FailCount and ProgSel. If NumProgs=0, go to DONE. Otherwise go to START.
- START: DutStart=1 for exactly START_LEN cycles, then WAIT_ACK. The run counter is cleared on entry.
- WAIT_ACK: DutStart=0. DutAck is sampled every cycle.
  - DutAck=1: go to RECORD.
  - DutAck=0: run counter +1, saturating at all-ones.
- Watchdog (if compiled): with DutAck=0 and counter = TIMEOUT-1, set the timeout flag, leave RunCycles = TIMEOUT, and go to RECORD. If DutAck=1 in the same cycle, DutAck wins and the timeout flag is not set.
- RECORD (one cycle): RunValid=1, RunIdx=ProgSel, RunCycles/RunTimeout drive the captured values, and FailCount increments on timeout.
  - If ProgSel = latched NumProgs-1, go to DONE.
  - Otherwise ProgSel+1 and go to START.
- DONE (one cycle): Done=1, then IDLE.
- DutAck outside WAIT_ACK is ignored. This covers DutAck still high from the previous halt while DutStart is high.
- Go while Busy=1 is ignored. NumProgs changes after latch have no effect.
- RunIdx, RunCycles and RunTimeout hold their last values until the next RECORD.

## Timing
- All outputs are registered.
- Reset values: DutStart=0, ProgSel=0, Busy=0, Done=0, RunValid=0, RunIdx=0, RunCycles=0, RunTimeout=0, FailCount=0. State resets to IDLE.
- Go accepted at edge n: DutStart=1 from cycle n+1 through n+START_LEN.
- DutAck first seen high in WAIT_ACK at cycle m: RunValid=1 at cycle m+1.
- Next launch: DutStart rises at m+2.
- Last program: Done=1 at m+2, Busy=0 at m+3.
- Reset_n low mid-run: everything returns to reset values immediately, DutStart drops asynchronously, and no RunValid or Done is emitted.

## Configuration
- SEQ_TIMEOUT_EN defined: watchdog as above; RunTimeout and FailCount are live.
- SEQ_TIMEOUT_EN undefined: WAIT_ACK exits only on DutAck. RunTimeout=0 and FailCount=0 constantly. The TIMEOUT parameter is unused.

## Structure
- Shared package seq_pkg holds the state enum (IDLE, START, WAIT_ACK, RECORD, DONE) and the default PW/CW constants.
- One sub-module, seq_run_counter: clear, enable, saturating CW-bit counter with a terminal-count compare to TIMEOUT-1. The compare is present only under SEQ_TIMEOUT_EN.

## Test plan
- Reset, Go with NumProgs=1, DutAck high 10 cycles after Start falls -> DutStart high 2 cycles; RunValid with RunIdx=0, RunCycles=10, RunTimeout=0; Done 1 cycle after RunValid.
- NumProgs=3 with Ack delays 0, 5, 1 -> three RunValid pulses with RunIdx 0, 1, 2 and RunCycles 0, 5, 1; one Done; ProgSel follows each run.
- DutAck held high during START from a prior halt -> ignored; RunCycles counts from the WAIT_ACK entry.
- SEQ_TIMEOUT_EN, TIMEOUT=8, DutAck never rises -> RunTimeout=1, RunCycles=8, FailCount=1. Also DutAck rising at the terminal cycle -> RunTimeout=0, RunCycles=7.
- NumProgs=0 -> Done pulse 1 cycle after Go; no DutStart, no RunValid.
- Reset_n low during WAIT_ACK, then a second Go while Busy -> DutStart drops asynchronously with all outputs at reset values; the Go while Busy is ignored and NumProgs is not re-latched.
